// File: rtl/vedic_mac_acc.sv
// vedic_mac_acc: batches unsigned 12-bit products from a 6x6 Vedic
// multiplier into ACC_W-bit sums of COUNT_N products, or fewer when flushed.
// Results use a valid/ready handshake, and no new product is accepted
// while a result is waiting.
// Optional build macro VEDIC_MAC_SAT_EN: when it is defined, the accumulator
// saturates at 2^ACC_W-1. By default it wraps. In both builds ovf is sticky.
module vedic_mac_acc #(
    parameter int ACC_W   = 20,
    parameter int COUNT_N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      prod,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] sum,
    output logic [7:0]       sum_cnt,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf_acc;
    logic             xfer;
    logic             release_out;
    logic [ACC_W:0]   add_full;

    // Add with one extra bit so the carry out of bit ACC_W-1 stays visible.
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                               input logic [11:0]      p);
        return {1'b0, a} + {{(ACC_W - 11){1'b0}}, p};
    endfunction

    // Fold the widened sum back to ACC_W bits: clamp or wrap.
    function automatic logic [ACC_W-1:0] limit(input logic [ACC_W:0] s);
`ifdef VEDIC_MAC_SAT_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    assign add_full  = add_ext(acc, prod);
    assign sum       = acc;
    assign sum_cnt   = cnt;
    assign ovf       = ovf_acc;

    // State register; reset always returns to accumulating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. A flush closes a batch only if the
    // batch holds something, counting a product accepted on the same edge.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        xfer        = 1'b0;
        release_out = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if ((xfer && (cnt == 8'(COUNT_N - 1))) ||
                    (flush && ((cnt != 8'd0) || xfer))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Accumulator, product count and sticky overflow. These values are held
    // through DONE because no transfer can happen there. They clear when
    // the result is handed off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (release_out) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (xfer) begin
            acc     <= limit(add_full);
            cnt     <= cnt + 8'd1;
            ovf_acc <= ovf_acc | add_full[ACC_W];
        end
    end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Scoreboard bench for vedic_mac_acc. Two instances receive the same inputs:
// one has the default width and one has ACC_W=14, so that overflow occurs.
// The driver keeps a batch-level model and pushes expected results.
// The monitor compares every presented result against the queue head.
module tb_vedic_mac_acc;

    localparam int W_BIG   = 20;
    localparam int W_SMALL = 14;
    localparam int CNT_N   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [11:0]        prod = '0;
    logic               in_valid = 1'b0;
    logic               flush = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready, s_in_ready;
    logic [W_BIG-1:0]   sum;
    logic [W_SMALL-1:0] s_sum;
    logic [7:0]         sum_cnt, s_sum_cnt;
    logic               ovf, s_ovf;
    logic               out_valid, s_out_valid;

    vedic_mac_acc #(.ACC_W(W_BIG), .COUNT_N(CNT_N)) dut (
        .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .sum(sum), .sum_cnt(sum_cnt),
        .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    vedic_mac_acc #(.ACC_W(W_SMALL), .COUNT_N(CNT_N)) dut_small (
        .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid),
        .in_ready(s_in_ready), .flush(flush), .sum(s_sum), .sum_cnt(s_sum_cnt),
        .ovf(s_ovf), .out_valid(s_out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint total;
        int     n;
    } batch_t;

    batch_t q[$];
    int     vectors = 0;
    int     miscompares = 0;
    bit     pending = 0;
    longint bt = 0;
    int     bn = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint exp_sum(input longint total, input int w);
        longint m = longint'(1) << w;
`ifdef VEDIC_MAC_SAT_EN
        return (total >= m) ? m - 1 : total;
`else
        return total % m;
`endif
    endfunction

    function automatic longint exp_ovf(input longint total, input int w);
        return (total >= (longint'(1) << w)) ? 1 : 0;
    endfunction

    // One clock cycle of stimulus. Handshake levels are checked against the
    // model at the negedge. The model then advances with the edge.
    task automatic step(input logic v, input logic [11:0] p, input logic f, input logic r);
        in_valid = v; prod = p; flush = f; out_ready = r;
        @(negedge clk);
        check("in_ready", in_ready, !pending);
        check("out_valid", out_valid, pending);
        check("s_in_ready", s_in_ready, !pending);
        check("s_out_valid", s_out_valid, pending);
        @(posedge clk);
        if (pending) begin
            if (r) pending = 0;
        end else begin
            if (v) begin
                bt += p;
                bn++;
            end
            if (bn == CNT_N || (f && bn > 0)) begin
                q.push_back('{total: bt, n: bn});
                pending = 1;
                bt = 0;
                bn = 0;
            end
        end
        #1;
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        check("rst_sum", sum, 0);
        check("rst_sum_cnt", sum_cnt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        q.delete();
        pending = 0;
        bt = 0;
        bn = 0;
        #1 rst = 1'b0;
    endtask

    // Monitor: compares every presented result and pops it on the handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got sum %0d expected no output", sum);
            end else begin
                check("sum", sum, exp_sum(q[0].total, W_BIG));
                check("sum_cnt", sum_cnt, q[0].n);
                check("ovf", ovf, exp_ovf(q[0].total, W_BIG));
                check("s_sum", s_sum, exp_sum(q[0].total, W_SMALL));
                check("s_sum_cnt", s_sum_cnt, q[0].n);
                check("s_ovf", s_ovf, exp_ovf(q[0].total, W_SMALL));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("init_sum", sum, 0);
        check("init_sum_cnt", sum_cnt, 0);
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 1);
        check("init_ovf", ovf, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full batch of 63*63 with an immediately ready sink.
        for (int i = 0; i < 8; i++) step(1, 12'd3969, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Short batch closed by a flush on its last transfer.
        step(1, 12'd10, 0, 1);
        step(1, 12'd20, 0, 1);
        step(1, 12'd30, 1, 1);
        step(0, 0, 0, 1);
        // A flush on an empty batch must produce nothing.
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // Back-pressure: the result holds and offered products wait.
        for (int i = 0; i < 8; i++) step(1, 12'd5, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 12'd7, 0, 0);
        step(1, 12'd7, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 12'd7, 0, 1);
        step(0, 0, 0, 1);

        // Reset in the middle of a batch, then a clean batch of ones.
        for (int i = 0; i < 4; i++) step(1, 12'd100, 0, 1);
        mid_reset();
        for (int i = 0; i < 8; i++) step(1, 12'd1, 0, 1);
        step(0, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [11:0] p;
            p = 12'($urandom_range(0, 63) * $urandom_range(0, 63));
            step(1'($urandom_range(0, 3) != 0), p,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
        end

        // Drain and confirm every expected result was consumed.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vedic_mac_acc.md
VEDIC_MAC_ACC -- requirements
Module: vedic_mac_acc

Interface
REQ-001 Parameter ACC_W, default 20, accumulator and sum width in bits; legal range 12..32.
REQ-002 Parameter COUNT_N, default 8, number of products per output sum; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 prod  input  12  unsigned 6x6 product from the upstream Vedic multiplier.
REQ-006 in_valid  input  1  prod is valid this cycle.
REQ-007 in_ready  output  1  block accepts prod this cycle.
REQ-008 flush  input  1  close the current batch early.
REQ-009 sum  output  ACC_W  accumulated sum of the batch.
REQ-010 sum_cnt  output  8  number of products contained in sum.
REQ-011 ovf  output  1  sum exceeded 2^ACC_W-1 during the batch.
REQ-012 out_valid  output  1  sum, sum_cnt and ovf are valid.
REQ-013 out_ready  input  1  downstream accepts the result.

Function
REQ-014 Two-state FSM: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-015 A transfer is in_valid & in_ready on a rising edge; an accepted prod updates acc <= acc + zero-extended prod and cnt <= cnt + 1 on that edge.
REQ-016 ACCUM->DONE on the edge that accepts the COUNT_N-th product of the batch.
REQ-017 ACCUM->DONE on an edge with flush=1 and (cnt>0 or a transfer on that edge); a product accepted on that edge is included in the sum.
REQ-018 flush=1 with cnt=0 and no transfer: ignored; state stays ACCUM, no output is produced.
REQ-019 flush while in DONE: ignored.
REQ-020 In DONE, sum/sum_cnt/ovf are held stable until out_valid & out_ready.
REQ-021 DONE->ACCUM on out_valid & out_ready; on that edge acc, cnt and ovf clear to 0.
REQ-022 in_ready is 0 in DONE, so no product is accepted on the handshake edge; the first product of the next batch is accepted at the earliest one cycle later.
REQ-023 Latency: the sum is visible with out_valid=1 the cycle after the edge on which the final product is accepted; throughput is COUNT_N+1 cycles per batch at best.
REQ-024 sum_cnt equals the number of products accepted in the batch (COUNT_N, or fewer if flushed).
REQ-025 Overflow, macro absent: acc wraps modulo 2^ACC_W; ovf is set sticky on the first carry out of bit ACC_W-1.

Reset
REQ-026 rst=1 asynchronously forces state ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, sum=0, sum_cnt=0; in_ready=1 while rst=1.
REQ-027 Reset during a partial batch or in DONE discards all state; no output is emitted for that batch.
REQ-028 After reset deasserts, the first rising edge accepts a transfer normally.

Configuration
REQ-029 Macro VEDIC_MAC_SAT_EN: when defined, an addition exceeding 2^ACC_W-1 clamps acc to 2^ACC_W-1 and sets ovf sticky; later products leave acc at the clamp value.
REQ-030 Without VEDIC_MAC_SAT_EN, wrap-around per REQ-025; ports and timing are identical in both builds.

Verification
REQ-031 Defaults; prod=63*63=3969 for 8 consecutive cycles, out_ready=1 -> out_valid one cycle after the 8th accept, sum=31752, sum_cnt=8, ovf=0.
REQ-032 Defaults; 3 products 10,20,30, with flush=1 on the 3rd transfer -> sum=60, sum_cnt=3; flush=1 alone with cnt=0 -> no out_valid.
REQ-033 Defaults; complete batch with out_ready=0 for 5 cycles -> sum stable, in_ready=0, held in_valid products not accepted; accepted on the first cycle after out_ready=1.
REQ-034 ACC_W=14, COUNT_N=8, 8x3969: macro absent -> sum=31752 mod 16384=15368, ovf=1; VEDIC_MAC_SAT_EN defined -> sum=16383, ovf=1.
REQ-035 Defaults; rst asserted mid-cycle after 4 accepts -> outputs reset immediately without a clock edge; the next 8 products of 1 -> sum=8, sum_cnt=8.
